// File: rtl/psx_ram_pkg.sv
// Shared types and ch2 port widths for the SDRAM write path.
// Imported by the write buffer, its FIFO and the bench.
package psx_ram_pkg;

    localparam int CH2_ADDR_W = 27;
    localparam int CH2_DATA_W = 32;
    localparam int CH2_BE_W   = 4;

    // Entries hold a word address; the byte offset is implied zero.
    typedef struct packed {
        logic [24:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_WAIT = 2'd2
    } wbuf_state_t;

    function automatic logic [CH2_ADDR_W-1:0] word_to_byte_addr(input logic [24:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Write-buffer storage: circular FIFO with occupancy count and a
// parallel word-address compare across every valid entry.
module wbuf_fifo
    import psx_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  wbuf_entry_t                 wr_entry_i,
    output wbuf_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o,
    input  logic [24:0]                 lookup_addr_i,
    output logic                        lookup_hit_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    wbuf_entry_t   mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;
    logic [PW-1:0] offs;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wr_entry_i;
        end
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        lookup_hit_o = 1'b0;
        offs         = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offs = PW'(i) - rptr_q;
            if (({1'b0, offs} < count_q) && (mem_q[i].addr == lookup_addr_i)) begin
                lookup_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_write_buffer.sv
// Posted-write buffer in front of SDRAM channel 2: queues byte-enabled
// writes and drains them in order, one request/accept handshake at a time.
module ram_write_buffer
    import psx_ram_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DRAIN_LEVEL = 6
) (
    input  logic                  clk1x,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [CH2_ADDR_W-1:0] wr_addr,
    input  logic [CH2_DATA_W-1:0] wr_data,
    input  logic [CH2_BE_W-1:0]   wr_be,
    output logic                  wr_full,
    output logic                  overflow,
    input  logic [CH2_ADDR_W-1:0] lookup_addr,
    output logic                  lookup_hit,
    input  logic                  flush,
    output logic                  empty,
    input  logic                  ram_idle,
    output logic                  ch2_req,
    output logic                  ch2_rnw,
    output logic [CH2_ADDR_W-1:0] ch2_addr,
    output logic [CH2_DATA_W-1:0] ch2_din,
    output logic [CH2_BE_W-1:0]   ch2_be,
    input  logic                  ch2_ready,
    output wbuf_state_t           dbg_state
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Handshake: ch2_req is a single-cycle pulse in REQ; the controller
    // answers later with a single-cycle ch2_ready, honoured only in WAIT.
    wbuf_state_t           state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic [CH2_ADDR_W-1:0] ch2_addr_q, ch2_addr_d;
    logic [CH2_DATA_W-1:0] ch2_din_q, ch2_din_d;
    logic [CH2_BE_W-1:0]   ch2_be_q, ch2_be_d;

    wbuf_entry_t           wr_entry;
    wbuf_entry_t           head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  load_head;
    logic                  drain_ok;
    logic                  unused_addr_lsbs;

    assign wr_entry         = '{addr: wr_addr[26:2], data: wr_data, be: wr_be};
    assign unused_addr_lsbs = ^{wr_addr[1:0], lookup_addr[1:0]};

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i         (clk1x),
        .rst_i         (reset),
        .push_i        (wr_req),
        .pop_i         (pop),
        .wr_entry_i    (wr_entry),
        .head_o        (head),
        .count_o       (fifo_count),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .lookup_addr_i (lookup_addr[26:2]),
        .lookup_hit_o  (lookup_hit)
    );

    assign drain_ok = !fifo_empty &&
                      (ram_idle || flush || (32'(fifo_count) >= DRAIN_LEVEL));

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        pop       = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (drain_ok) begin
                    state_d   = WB_REQ;
                    load_head = 1'b1;
                end
            end
            WB_REQ: begin
                state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (ch2_ready) begin
                    pop     = 1'b1;
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // The ch2 payload is captured on entry to REQ and held until the next
    // drain, so it is stable through the accept and the cycle after.
    always_comb begin
        overflow_d = overflow_q | (wr_req & fifo_full);
        ch2_addr_d = ch2_addr_q;
        ch2_din_d  = ch2_din_q;
        ch2_be_d   = ch2_be_q;
        if (load_head) begin
            ch2_addr_d = word_to_byte_addr(head.addr);
            ch2_din_d  = head.data;
            ch2_be_d   = head.be;
        end
    end

    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            state_q    <= WB_IDLE;
            overflow_q <= 1'b0;
            ch2_addr_q <= '0;
            ch2_din_q  <= '0;
            ch2_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            ch2_addr_q <= ch2_addr_d;
            ch2_din_q  <= ch2_din_d;
            ch2_be_q   <= ch2_be_d;
        end
    end

    assign wr_full   = fifo_full;
    assign overflow  = overflow_q;
    assign empty     = fifo_empty && (state_q == WB_IDLE);
    assign ch2_req   = (state_q == WB_REQ);
    assign ch2_rnw   = 1'b0;
    assign ch2_addr  = ch2_addr_q;
    assign ch2_din   = ch2_din_q;
    assign ch2_be    = ch2_be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_write_buffer.sv
// Bench for ram_write_buffer: a default instance (DRAIN_LEVEL 6) and a
// no-threshold instance (DRAIN_LEVEL 9) share every input.
module tb_ram_write_buffer;
    import psx_ram_pkg::*;

    logic        clk1x = 1'b0;
    logic        reset = 1'b0;
    logic        wr_req = 1'b0;
    logic [26:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic [26:0] lookup_addr = '0;
    logic        flush = 1'b0;
    logic        ram_idle = 1'b0;
    logic        ch2_ready = 1'b0;

    logic        wr_full, overflow, lookup_hit, empty, ch2_req, ch2_rnw;
    logic [26:0] ch2_addr;
    logic [31:0] ch2_din;
    logic [3:0]  ch2_be;
    wbuf_state_t dbg_state;

    logic        n_full, n_ovf, n_hit, n_empty, n_req, n_rnw;
    logic [26:0] n_addr;
    logic [31:0] n_din;
    logic [3:0]  n_be;
    wbuf_state_t n_state;

    int checks = 0;
    int errors = 0;
    logic [62:0] exp_q[$];

    always #5 clk1x = ~clk1x;

    ram_write_buffer #(.DEPTH(8), .DRAIN_LEVEL(6)) u_dut (
        .clk1x(clk1x), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .wr_full(wr_full), .overflow(overflow),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .flush(flush),
        .empty(empty), .ram_idle(ram_idle), .ch2_req(ch2_req), .ch2_rnw(ch2_rnw),
        .ch2_addr(ch2_addr), .ch2_din(ch2_din), .ch2_be(ch2_be),
        .ch2_ready(ch2_ready), .dbg_state(dbg_state)
    );

    ram_write_buffer #(.DEPTH(8), .DRAIN_LEVEL(9)) u_nd (
        .clk1x(clk1x), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .wr_full(n_full), .overflow(n_ovf),
        .lookup_addr(lookup_addr), .lookup_hit(n_hit), .flush(flush),
        .empty(n_empty), .ram_idle(ram_idle), .ch2_req(n_req), .ch2_rnw(n_rnw),
        .ch2_addr(n_addr), .ch2_din(n_din), .ch2_be(n_be),
        .ch2_ready(ch2_ready), .dbg_state(n_state)
    );

    typedef struct {
        logic        wr_req;
        logic [26:0] wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        logic        ram_idle;
        logic        ch2_ready;
        logic [26:0] lookup_addr;
        logic        exp_req;
        logic        exp_empty;
        logic        exp_hit;
        logic        chk_ch2;
        logic [26:0] exp_addr;
        logic [31:0] exp_din;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic req, logic [26:0] wa, logic [31:0] wd, logic [3:0] wb,
                                logic idle, logic rdy, logic [26:0] lk,
                                logic e_req, logic e_empty, logic e_hit,
                                logic chk, logic [26:0] ea, logic [31:0] ed, logic [3:0] eb);
        vec_t v;
        v.wr_req = req; v.wr_addr = wa; v.wr_data = wd; v.wr_be = wb;
        v.ram_idle = idle; v.ch2_ready = rdy; v.lookup_addr = lk;
        v.exp_req = e_req; v.exp_empty = e_empty; v.exp_hit = e_hit;
        v.chk_ch2 = chk; v.exp_addr = ea; v.exp_din = ed; v.exp_be = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle_idle();
        @(negedge clk1x);
        wr_req = 1'b0;
        ch2_ready = 1'b0;
        #1;
    endtask

    task automatic cycle_push(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk1x);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        ch2_ready = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk1x);
        reset = 1'b1;
        wr_req = 1'b0; ch2_ready = 1'b0; flush = 1'b0; ram_idle = 1'b0;
        repeat (2) @(negedge clk1x);
        reset = 1'b0;
    endtask

    // Waits (bounded) for a request on the selected instance, records the
    // payload, waits lat cycles in WAIT, then pulses ch2_ready, optionally
    // pushing a new entry in that same cycle.
    task automatic drain_one(input bit sel_nd, input int lat, input bit push_en,
                             input logic [62:0] push_ent, output logic [62:0] got, output bit ok);
        ok = 1'b0;
        got = '0;
        for (int t = 0; t < 40 && !ok; t++) begin
            cycle_idle();
            if ((sel_nd ? n_req : ch2_req) === 1'b1) begin
                ok = 1'b1;
                got = sel_nd ? {n_addr, n_din, n_be} : {ch2_addr, ch2_din, ch2_be};
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got no ch2_req expected one within 40 cycles");
        end else begin
            for (int t = 0; t < lat; t++) cycle_idle();
            @(negedge clk1x);
            ch2_ready = 1'b1;
            wr_req = push_en;
            if (push_en) begin
                wr_addr = push_ent[62:36]; wr_data = push_ent[35:4]; wr_be = push_ent[3:0];
            end
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [62:0] got;
        logic [62:0] ent;
        bit          ok;
        bit          seen;

        // Single write then lookup sequence; one row per clock cycle.
        vecs.push_back(mk(1, 27'h0001234, 32'hDEADBEEF, 4'hF, 1, 0, 27'h0001234, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 1, 0, 1, 1, 27'h0001234, 32'hDEADBEEF, 4'hF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 0, 0, 1, 1, 27'h0001234, 32'hDEADBEEF, 4'hF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 0, 0, 1, 1, 27'h0001234, 32'hDEADBEEF, 4'hF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 27'h0001234, 0, 0, 1, 1, 27'h0001234, 32'hDEADBEEF, 4'hF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 0, 1, 0, 1, 27'h0001234, 32'hDEADBEEF, 4'hF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0001234, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 27'h0000102, 32'h11112222, 4'h3, 0, 0, 27'h0000100, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 27'h0000100, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 27'h0000104, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 27'h0000103, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 27'h0000100, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 27'h0000100, 1, 0, 1, 1, 27'h0000100, 32'h11112222, 4'h3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 27'h0000100, 0, 0, 1, 1, 27'h0000100, 32'h11112222, 4'h3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 27'h0000100, 0, 1, 0, 1, 27'h0000100, 32'h11112222, 4'h3));

        // Reset values on both instances.
        @(negedge clk1x);
        reset = 1'b1;
        #1;
        check("rst_req", ch2_req, 1'b0);
        check("rst_rnw", ch2_rnw, 1'b0);
        check("rst_ch2", {ch2_addr, ch2_din, ch2_be}, 63'd0);
        check("rst_full", wr_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_state", dbg_state, WB_IDLE);
        check("rst_nd_empty", n_empty, 1'b1);
        check("rst_nd_req", n_req, 1'b0);
        apply_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk1x);
            wr_req = vecs[i].wr_req; wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data; wr_be = vecs[i].wr_be;
            ram_idle = vecs[i].ram_idle; ch2_ready = vecs[i].ch2_ready;
            lookup_addr = vecs[i].lookup_addr;
            #1;
            check($sformatf("v%0d_req", i), ch2_req, vecs[i].exp_req);
            check($sformatf("v%0d_empty", i), empty, vecs[i].exp_empty);
            check($sformatf("v%0d_hit", i), lookup_hit, vecs[i].exp_hit);
            check($sformatf("v%0d_full", i), wr_full, 1'b0);
            if (vecs[i].chk_ch2) begin
                check($sformatf("v%0d_addr", i), ch2_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_din", i), ch2_din, vecs[i].exp_din);
                check($sformatf("v%0d_be", i), ch2_be, vecs[i].exp_be);
            end
        end

        // Fill the no-threshold instance, overflow it, then flush in order.
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            ent = {27'h0002000 + 27'(i * 4), 32'($urandom), 4'($urandom_range(1, 15))};
            exp_q.push_back(ent);
            cycle_push(ent[62:36], ent[35:4], ent[3:0]);
            check($sformatf("fill%0d_full", i), n_full, 1'b0);
        end
        cycle_push(27'h0002F00, 32'hBAD0BAD0, 4'hF);
        check("fill_full8", n_full, 1'b1);
        check("fill_ovf_before", n_ovf, 1'b0);
        lookup_addr = 27'h0002F00;
        cycle_idle();
        check("ovf_set", n_ovf, 1'b1);
        check("ovf_full_held", n_full, 1'b1);
        check("ovf_no_req", n_req, 1'b0);
        check("ovf_dropped_hit", n_hit, 1'b0);
        lookup_addr = 27'h0002000;
        #1;
        check("fill_head_hit", n_hit, 1'b1);
        flush = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drain_one(1'b1, i % 3, 1'b0, '0, got, ok);
            if (ok) check($sformatf("flush%0d_entry", i), got, exp_q.pop_front());
        end
        flush = 1'b0;
        cycle_idle();
        cycle_idle();
        check("flush_empty", n_empty, 1'b1);
        check("flush_not_full", n_full, 1'b0);
        check("ovf_sticky", n_ovf, 1'b1);
        apply_reset();
        #1;
        check("ovf_cleared", n_ovf, 1'b0);

        // DRAIN_LEVEL threshold on the default instance with ram_idle low.
        for (int i = 0; i < 5; i++) begin
            cycle_push(27'h0004000 + 27'(i * 4), 32'h1000 + 32'(i), 4'h1);
            check($sformatf("thr_push%0d_req", i), ch2_req, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle_idle();
            check($sformatf("thr_wait%0d_req", i), ch2_req, 1'b0);
        end
        cycle_push(27'h0004014, 32'h1005, 4'h1);
        check("thr_n_req", ch2_req, 1'b0);
        cycle_idle();
        check("thr_n1_req", ch2_req, 1'b0);
        cycle_idle();
        check("thr_n2_req", ch2_req, 1'b1);
        check("thr_n2_addr", ch2_addr, 27'h0004000);

        // Push in the same cycle as the accept with three entries queued.
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            ent = {27'h0005000 + 27'(i * 4), 32'($urandom), 4'($urandom_range(1, 15))};
            exp_q.push_back(ent);
            cycle_push(ent[62:36], ent[35:4], ent[3:0]);
        end
        cycle_idle();
        check("pp_hold_req", ch2_req, 1'b0);
        ram_idle = 1'b1;
        ent = {27'h0005100, 32'hC0FFEE00, 4'hA};
        drain_one(1'b0, 2, 1'b1, ent, got, ok);
        if (ok) check("pp_first", got, exp_q.pop_front());
        exp_q.push_back(ent);
        for (int i = 0; i < 3; i++) begin
            drain_one(1'b0, i, 1'b0, '0, got, ok);
            if (ok) check($sformatf("pp_drain%0d", i), got, exp_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            cycle_idle();
            check($sformatf("pp_done%0d_req", i), ch2_req, 1'b0);
        end
        check("pp_empty", empty, 1'b1);

        // Reset while waiting for the accept with four entries queued.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle_push(27'h0006000 + 27'(i * 4), 32'h6000 + 32'(i), 4'hF);
        end
        ram_idle = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            cycle_idle();
            if (ch2_req === 1'b1) seen = 1'b1;
        end
        check("rw_req_seen", seen, 1'b1);
        ram_idle = 1'b0;
        cycle_idle();
        check("rw_in_wait", dbg_state, WB_WAIT);
        lookup_addr = 27'h0006000;
        #2;
        reset = 1'b1;
        #1;
        check("rw_req", ch2_req, 1'b0);
        check("rw_empty", empty, 1'b1);
        check("rw_ovf", overflow, 1'b0);
        check("rw_state", dbg_state, WB_IDLE);
        check("rw_addr", ch2_addr, 27'd0);
        check("rw_hit", lookup_hit, 1'b0);
        @(negedge clk1x);
        reset = 1'b0;
        ch2_ready = 1'b1;
        #1;
        cycle_idle();
        check("rw_late_rdy_empty", empty, 1'b1);
        ram_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle_idle();
            check($sformatf("rw_after%0d_req", i), ch2_req, 1'b0);
            check($sformatf("rw_after%0d_empty", i), empty, 1'b1);
        end
        check("rw_full", wr_full, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
